// File: rtl/uart_rx_packet_ctrl.sv
// ============================================================================
// uart_rx_packet_ctrl: frame sequencer (SYNC CMD LEN payload CHK) behind a UART receiver.
// Optional inter-byte timeout enabled by macro RX_PKT_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_packet_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_LEN       = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_TICKS = 192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] pkt_cmd,
  output logic [7:0]            pkt_len,
  output logic                  pkt_ok,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  ovr,
  output logic                  busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int PW = AW + 1;
  localparam int CW = (PW > 8) ? PW : 8;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] cmd_r, cmd_nxt;
  logic [7:0]            len_r, len_nxt;
  logic [DATA_WIDTH-1:0] chk, chk_nxt;
  logic [PW-1:0]         wr_ptr, wr_nxt;
  logic [PW-1:0]         rd_ptr, rd_nxt;
  logic [DATA_WIDTH-1:0] pkt_cmd_nxt, out_data_nxt;
  logic [7:0]            pkt_len_nxt;
  logic                  pkt_ok_nxt, out_valid_nxt, out_last_nxt, err_nxt, ovr_nxt;
  logic [1:0]            err_code_nxt;
  logic                  wr_en;
  logic                  timeout;
  logic [7:0]            rx_byte;
  logic [PW-1:0]         rd_inc;

  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  assign rx_byte = rx_data[7:0];
  assign rd_inc  = rd_ptr + 1'b1;
  assign busy    = (state != S_HUNT);

`ifdef RX_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt;
  logic          active;

  assign active  = (state == S_CMD) || (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign timeout = active && !rx_done && (tcnt == TW'(TIMEOUT_TICKS));

  always_ff @(posedge clk) begin
    if (rst || rx_done || !active) begin
      tcnt <= '0;
    end else if (tick && (tcnt != TW'(TIMEOUT_TICKS))) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_tick;
  assign timeout     = 1'b0;
  assign unused_tick = tick & (TIMEOUT_TICKS != 0);
`endif

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd_r;
    len_nxt       = len_r;
    chk_nxt       = chk;
    wr_nxt        = wr_ptr;
    rd_nxt        = rd_ptr;
    pkt_cmd_nxt   = pkt_cmd;
    pkt_len_nxt   = pkt_len;
    pkt_ok_nxt    = 1'b0;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    err_nxt       = 1'b0;
    err_code_nxt  = err_code;
    ovr_nxt       = 1'b0;
    wr_en         = 1'b0;

    case (state)
      S_HUNT: begin
        if (rx_done && (rx_data == SYNC_BYTE)) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (rx_done) begin
          cmd_nxt   = rx_data;
          chk_nxt   = rx_data;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          len_nxt = rx_byte;
          chk_nxt = chk ^ rx_data;
          wr_nxt  = '0;
          if (CW'(rx_byte) > CW'(MAX_LEN)) begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'b01;
            state_nxt    = S_HUNT;
          end else if (rx_byte == 8'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done) begin
          wr_en   = 1'b1;
          chk_nxt = chk ^ rx_data;
          wr_nxt  = wr_ptr + 1'b1;
          if (CW'(wr_ptr) == CW'(len_r) - CW'(1)) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_data == chk) begin
            pkt_cmd_nxt = cmd_r;
            pkt_len_nxt = len_r;
            pkt_ok_nxt  = 1'b1;
            if (len_r != 8'd0) begin
              // Preload the first byte so it is valid alongside pkt_ok.
              rd_nxt        = '0;
              out_valid_nxt = 1'b1;
              out_data_nxt  = mem[0];
              out_last_nxt  = (len_r == 8'd1);
              state_nxt     = S_DRAIN;
            end else begin
              state_nxt = S_HUNT;
            end
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'b10;
            state_nxt    = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        ovr_nxt = rx_done;
        if (out_ready) begin
          if (out_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            state_nxt     = S_HUNT;
          end else begin
            rd_nxt       = rd_inc;
            out_data_nxt = mem[rd_inc[AW-1:0]];
            out_last_nxt = (CW'(rd_inc) == CW'(len_r) - CW'(1));
          end
        end
      end
      default: state_nxt = S_HUNT;
    endcase

    if (timeout) begin
      err_nxt      = 1'b1;
      err_code_nxt = 2'b11;
      state_nxt    = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HUNT;
      cmd_r     <= '0;
      len_r     <= '0;
      chk       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_cmd   <= '0;
      pkt_len   <= '0;
      pkt_ok    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_r     <= cmd_nxt;
      len_r     <= len_nxt;
      chk       <= chk_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      pkt_cmd   <= pkt_cmd_nxt;
      pkt_len   <= pkt_len_nxt;
      pkt_ok    <= pkt_ok_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      err       <= err_nxt;
      err_code  <= err_code_nxt;
      ovr       <= ovr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packet_ctrl.sv
// ============================================================================
// tb_uart_rx_packet_ctrl: scoreboard bench for the UART frame sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_ready = 1'b1;
  logic [7:0] pkt_cmd, out_data;
  logic [7:0] pkt_len;
  logic       pkt_ok, out_valid, out_last, err, ovr, busy;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt  = 0;

  logic [8:0]  pay_q[$];   // {last, data}
  logic [15:0] pkt_q[$];   // {cmd, len}
  logic [1:0]  err_q[$];

  uart_rx_packet_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .rx_done(rx_done), .rx_data(rx_data),
    .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pkt_ok(pkt_ok),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .err(err), .err_code(err_code), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the following cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] pay[$], input logic bad_chk);
    logic [7:0] c;
    c = cmd ^ len;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(len);
    foreach (pay[i]) begin
      send_byte(pay[i]);
      c = c ^ pay[i];
    end
    if (bad_chk) begin
      err_q.push_back(2'b10);
      send_byte(c ^ 8'h07);
    end else begin
      pkt_q.push_back({cmd, len});
      foreach (pay[i]) pay_q.push_back({(i == pay.size() - 1), pay[i]});
      send_byte(c);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || out_valid) && n < bound) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= bound) check("idle_wait_expired", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (pay_q.size() == 0) check("unexpected_payload", {23'd0, out_last, out_data}, 32'h1ff);
        else check("payload", {23'd0, out_last, out_data}, {23'd0, pay_q.pop_front()});
      end
      if (pkt_ok) begin
        if (pkt_q.size() == 0) check("unexpected_pkt_ok", {16'd0, pkt_cmd, pkt_len}, 32'hffff);
        else check("pkt_cmd_len", {16'd0, pkt_cmd, pkt_len}, {16'd0, pkt_q.pop_front()});
      end
      if (err) begin
        if (err_q.size() == 0) check("unexpected_err", {30'd0, err_code}, 32'hff);
        else check("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
      end
      if (ovr) ovr_cnt++;
    end
  end

  logic [7:0] p3[$];
  logic [7:0] p0[$];

  initial begin
    p3 = '{8'h11, 8'h22, 8'h33};
    p0 = {};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {20'd0, pkt_ok, out_valid, out_last, err, ovr, err_code, pkt_cmd[0]}, 32'd0);
    check("rst_pkt", {16'd0, pkt_cmd, pkt_len}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Good frame: first byte valid with pkt_ok one cycle after CHK.
    out_ready = 1'b1;
    send_frame(8'h10, 8'd3, p3, 1'b0);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_pkt_ok", {31'd0, pkt_ok}, 32'd1);
    check("first_data", {24'd0, out_data}, 32'h11);
    wait_idle(50);
    check("good_no_err", {30'd0, err_code}, 32'd0);

    // Bad checksum then a good frame.
    send_frame(8'h10, 8'd3, p3, 1'b1);
    repeat (3) begin
      check("bad_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("bad_code_held", {30'd0, err_code}, 32'd2);
    send_frame(8'h10, 8'd3, p3, 1'b0);
    wait_idle(50);

    // Zero-length frame.
    send_frame(8'h07, 8'd0, p0, 1'b0);
    check("zero_len_busy", {31'd0, busy}, 32'd0);
    check("zero_len_valid", {31'd0, out_valid}, 32'd0);
    check("zero_len_pktlen", {24'd0, pkt_len}, 32'd0);

    // LEN above MAX_LEN, then a good frame.
    err_q.push_back(2'b01);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    check("len_err_pulse", {31'd0, err}, 32'd1);
    check("len_err_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h10, 8'd3, p3, 1'b0);
    wait_idle(50);

    // Garbage before SYNC is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garbage_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h10, 8'd3, p3, 1'b0);
    wait_idle(50);

    // Stall during drain with two incoming bytes.
    out_ready = 1'b0;
    send_frame(8'h10, 8'd3, p3, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_data", {24'd0, out_data}, 32'h11);
    check("stall_last", {31'd0, out_last}, 32'd0);
    check("ovr_count", ovr_cnt, 32'd2);
    check("err_code_held", {30'd0, err_code}, 32'd1);
    out_ready = 1'b1;
    wait_idle(50);

    // Partial frame left idle.
    send_byte(8'hA5);
    send_byte(8'h10);
`ifdef RX_PKT_TIMEOUT_EN
    repeat (40) @(posedge clk);
    #1 check("to_not_early", {31'd0, busy}, 32'd1);
    err_q.push_back(2'b11);
    wait_idle(1200);
    check("to_code", {30'd0, err_code}, 32'd3);
    check("to_busy", {31'd0, busy}, 32'd0);
`else
    repeat (1000) @(posedge clk);
    #1 check("no_to_busy", {31'd0, busy}, 32'd1);
    check("no_to_err", {30'd0, err_code}, 32'd1);
`endif

    // Reset mid-frame: silent return to HUNT.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_code", {30'd0, err_code}, 32'd0);
    @(posedge clk);
    #1;
    check("pay_q_empty", pay_q.size(), 32'd0);
    check("pkt_q_empty", pkt_q.size(), 32'd0);
    check("err_q_empty", err_q.size(), 32'd0);
    check("ovr_total", ovr_cnt, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
